// File: rtl/voq_sched_pkg.sv
// Shared switch-fabric types for the VOQ scheduler: port count, port index type and FSM states.
package switch_pkg;

  localparam int PORT_NUM   = 4;
  localparam int PORT_IDX_W = $clog2(PORT_NUM);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCEPT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/voq_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request bit at or after ptr, wrapping.
// PORT_NUM must match switch_pkg::PORT_NUM because ptr uses the shared port_idx_t.
module rr_arbiter #(
  parameter int PORT_NUM = switch_pkg::PORT_NUM
) (
  input  logic [PORT_NUM-1:0] req,
  input  switch_pkg::port_idx_t ptr,
  output logic [PORT_NUM-1:0] grant,
  output switch_pkg::port_idx_t idx,
  output logic                found
);

  import switch_pkg::*;

  port_idx_t cand;

  // Power-of-two port count lets the index wrap by plain truncation.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      cand = port_idx_t'(int'(ptr) + k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voq_sched.sv
// Single-iteration iSLIP crossbar scheduler; one matching per 4-cycle round.
// Optional VOQ_SCHED_STATS_EN adds round and match counters.
module voq_sched #(
  parameter int PORT_NUM = switch_pkg::PORT_NUM
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  experimenting,
  input  logic                                  sched_start,
  input  logic [PORT_NUM*PORT_NUM-1:0]          voq_req,
  output logic                                  busy,
  output logic                                  sched_done,
  output logic [PORT_NUM-1:0]                   match_valid,
`ifdef VOQ_SCHED_STATS_EN
  output logic [PORT_NUM*$clog2(PORT_NUM)-1:0]  match_egress,
  output logic [31:0]                           sched_rounds,
  output logic [31:0]                           sched_matches
`else
  output logic [PORT_NUM*$clog2(PORT_NUM)-1:0]  match_egress
`endif
);

  import switch_pkg::*;

  localparam int W = PORT_IDX_W;

  sched_state_t                 state;
  logic [PORT_NUM*PORT_NUM-1:0] req_q;
  logic [PORT_NUM-1:0]          gnt_q      [PORT_NUM];
  port_idx_t                    grant_ptr  [PORT_NUM];
  port_idx_t                    accept_ptr [PORT_NUM];

  logic [PORT_NUM-1:0]          col_req    [PORT_NUM];
  logic [PORT_NUM-1:0]          gnt_onehot [PORT_NUM];
  port_idx_t                    gnt_idx    [PORT_NUM];
  logic [PORT_NUM-1:0]          gnt_found;
  logic [PORT_NUM*W-1:0]        unused_gnt_idx;

  logic [PORT_NUM-1:0]          acc_req    [PORT_NUM];
  logic [PORT_NUM-1:0]          acc_onehot [PORT_NUM];
  port_idx_t                    acc_idx    [PORT_NUM];
  logic [PORT_NUM-1:0]          acc_found;

  // col_req[j] is the set of ingresses requesting egress j; acc_req[i] the egresses granting ingress i.
  always_comb begin
    for (int a = 0; a < PORT_NUM; a++) begin
      col_req[a] = '0;
      acc_req[a] = '0;
    end
    for (int j = 0; j < PORT_NUM; j++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        col_req[j][i] = req_q[i*PORT_NUM+j];
        acc_req[i][j] = gnt_q[j][i];
      end
    end
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
    rr_arbiter #(.PORT_NUM(PORT_NUM)) u_grant (
      .req   (col_req[g]),
      .ptr   (grant_ptr[g]),
      .grant (gnt_onehot[g]),
      .idx   (gnt_idx[g]),
      .found (gnt_found[g])
    );

    rr_arbiter #(.PORT_NUM(PORT_NUM)) u_accept (
      .req   (acc_req[g]),
      .ptr   (accept_ptr[g]),
      .grant (acc_onehot[g]),
      .idx   (acc_idx[g]),
      .found (acc_found[g])
    );

    assign unused_gnt_idx[g*W +: W] = gnt_idx[g];
  end

  // Pointers only move for accepted pairs, which is what makes iSLIP starvation-free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      sched_done   <= 1'b0;
      match_valid  <= '0;
      match_egress <= '0;
      req_q        <= '0;
      for (int j = 0; j < PORT_NUM; j++) begin
        gnt_q[j]      <= '0;
        grant_ptr[j]  <= '0;
        accept_ptr[j] <= '0;
      end
    end else begin
      sched_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sched_start && experimenting) begin
            req_q <= voq_req;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          for (int j = 0; j < PORT_NUM; j++) begin
            gnt_q[j] <= gnt_found[j] ? gnt_onehot[j] : '0;
          end
          state <= ACCEPT;
        end
        ACCEPT: begin
          for (int i = 0; i < PORT_NUM; i++) begin
            match_valid[i]        <= acc_found[i];
            match_egress[i*W +: W] <= acc_found[i] ? acc_idx[i] : '0;
            if (acc_found[i]) begin
              accept_ptr[i] <= acc_idx[i] + 1'b1;
            end
          end
          for (int j = 0; j < PORT_NUM; j++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
              if (acc_onehot[i][j]) begin
                grant_ptr[j] <= port_idx_t'(i + 1);
              end
            end
          end
          sched_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VOQ_SCHED_STATS_EN
  // match_valid already holds this round's result during DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sched_rounds  <= '0;
      sched_matches <= '0;
    end else if (state == DONE) begin
      sched_rounds  <= sched_rounds + 32'd1;
      sched_matches <= sched_matches + 32'($countones(match_valid));
    end
  end
`endif

endmodule
